// File: rtl/leaf_controller_pkg.sv
// Shared message-format definitions for the leaf controller: type codes,
// field positions, controller states and the result word layout.
package leaf_controller_pkg;

   localparam int MSG_W     = 64;
   localparam int TYPE_LSB  = 40;
   localparam int FLAGS_LSB = 0;

   localparam logic [7:0] START_DECODING_MSG      = 8'h01;
   localparam logic [7:0] MEASUREMENT_DATA_HEADER = 8'h02;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_HEADER,
      LOAD_DATA,
      DECODE,
      SEND_RESULT
   } state_t;

   typedef struct packed {
      logic [7:0]  dest;
      logic [7:0]  src;
      logic [7:0]  iters;
      logic [15:0] cycles;
      logic [22:0] rsvd;
      logic        sat;
   } result_t;

   function automatic logic [7:0] msg_type(input logic [MSG_W-1:0] msg);
      return msg[TYPE_LSB +: 8];
   endfunction

endpackage

// File: rtl/leaf_controller.sv
// Leaf-side decode controller: collects measurement payload from the root hub,
// launches the decoder, times it, and returns a single result message.
module leaf_controller
   import leaf_controller_pkg::*;
#(
   parameter logic [7:0] LEAF_ID    = 8'd1,
   parameter int         MEAS_WORDS = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [MSG_W-1:0]             rx_data,
   input  logic                         rx_valid,
   output logic                         rx_ready,
   output logic [MSG_W-1:0]             tx_data,
   output logic                         tx_valid,
   input  logic                         tx_ready,
   output logic [MSG_W*MEAS_WORDS*2-1:0] meas_data,
   output logic                         multi_fpga,
   output logic                         fusion_on,
   output logic                         decode_start,
   input  logic                         decode_done,
   input  logic [7:0]                   decode_iters
);

   localparam int NUM_WORDS = 2 * MEAS_WORDS;
   localparam int CNT_W     = (MEAS_WORDS > 1) ? $clog2(MEAS_WORDS) : 1;
   localparam int IDX_W     = $clog2(NUM_WORDS);

   state_t           state_q, state_d;
   logic             stage_q;
   logic [CNT_W-1:0] word_cnt_q;
   logic [15:0]      cyc_q, cyc_inc;
   logic [MSG_W-1:0] meas_q [NUM_WORDS];
   logic [IDX_W-1:0] widx;
   logic [7:0]       rx_type;
   logic             rx_fire, last_word, enter_decode;
   result_t          result;

   assign rx_fire      = rx_valid && rx_ready;
   assign rx_type      = msg_type(rx_data);
   assign last_word    = (word_cnt_q == CNT_W'(MEAS_WORDS - 1));
   assign widx         = stage_q ? IDX_W'(MEAS_WORDS) + IDX_W'(word_cnt_q) : IDX_W'(word_cnt_q);
   assign enter_decode = (state_q == LOAD_DATA) && (state_d == DECODE);
   assign cyc_inc      = (cyc_q == 16'hFFFF) ? cyc_q : cyc_q + 16'd1;

   // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      // NOTE: default first so no path through the case leaves state_d unassigned (no latch).
      state_d = state_q;
      unique case (state_q)
         IDLE:        if (rx_fire && rx_type == START_DECODING_MSG) state_d = WAIT_HEADER;
         WAIT_HEADER: if (rx_fire && rx_type == MEASUREMENT_DATA_HEADER) state_d = LOAD_DATA;
         LOAD_DATA:   if (rx_fire && last_word)
                         state_d = (fusion_on && !stage_q) ? WAIT_HEADER : DECODE;
         DECODE:      if (decode_done) state_d = SEND_RESULT;
         SEND_RESULT: if (tx_ready) state_d = IDLE;
         default:     state_d = IDLE;
      endcase
   end

   always_comb begin
      rx_ready = 1'b0;
      tx_valid = 1'b0;
      unique case (state_q)
         IDLE, WAIT_HEADER, LOAD_DATA: rx_ready = 1'b1;
         SEND_RESULT:                  tx_valid = 1'b1;
         default:                      ;
      endcase
   end

   // The done cycle itself counts, so the captured value is the incremented one.
   always_comb begin
      result        = '0;
      result.src    = LEAF_ID;
      result.iters  = decode_iters;
      result.cycles = cyc_inc;
      result.sat    = (cyc_inc == 16'hFFFF);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         multi_fpga   <= 1'b0;
         fusion_on    <= 1'b0;
         stage_q      <= 1'b0;
         word_cnt_q   <= '0;
         cyc_q        <= '0;
         tx_data      <= '0;
         decode_start <= 1'b0;
         // NOTE: the measurement buffer is a visible output, so it is cleared on reset like any other register.
         for (int i = 0; i < NUM_WORDS; i++) meas_q[i] <= '0;
      end else begin
         decode_start <= enter_decode;
         unique case (state_q)
            IDLE: begin
               if (rx_fire && rx_type == START_DECODING_MSG) begin
                  multi_fpga <= rx_data[FLAGS_LSB];
                  fusion_on  <= rx_data[FLAGS_LSB+1];
                  stage_q    <= 1'b0;
               end
            end
            WAIT_HEADER: begin
               if (rx_fire && rx_type == START_DECODING_MSG) begin
                  multi_fpga <= rx_data[FLAGS_LSB];
                  fusion_on  <= rx_data[FLAGS_LSB+1];
               end else if (rx_fire && rx_type == MEASUREMENT_DATA_HEADER) begin
                  stage_q    <= rx_data[FLAGS_LSB];
                  word_cnt_q <= '0;
               end
            end
            LOAD_DATA: begin
               if (rx_fire) begin
                  meas_q[widx] <= rx_data;
                  word_cnt_q   <= word_cnt_q + CNT_W'(1);
               end
            end
            DECODE: begin
               cyc_q <= cyc_inc;
               if (decode_done) tx_data <= result;
            end
            default: ;
         endcase
         if (enter_decode) cyc_q <= '0;
      end
   end

   for (genvar g = 0; g < NUM_WORDS; g++) begin : g_meas_out
      assign meas_data[g*MSG_W +: MSG_W] = meas_q[g];
   end

endmodule

// File: tb/tb_leaf_controller.sv
// Self-checking bench for leaf_controller: randomized message sequences
// compared against a buffer/result model derived from the message rules.
`timescale 1ns/1ps
module tb_leaf_controller;
   import leaf_controller_pkg::*;

   localparam int         MW  = 2;
   localparam logic [7:0] LID = 8'd1;

   logic                 clk = 1'b0;
   logic                 reset = 1'b1;
   logic [63:0]          rx_data = '0;
   logic                 rx_valid = 1'b0;
   logic                 rx_ready;
   logic [63:0]          tx_data;
   logic                 tx_valid;
   logic                 tx_ready = 1'b0;
   logic [64*MW*2-1:0]   meas_data;
   logic                 multi_fpga, fusion_on, decode_start;
   logic                 decode_done = 1'b0;
   logic [7:0]           decode_iters = '0;

   int checks = 0, failures = 0;
   int start_cnt = 0, xfer_cnt = 0;
   logic [63:0] exp_meas [2*MW];

   leaf_controller #(.LEAF_ID(LID), .MEAS_WORDS(MW)) dut (
      .clk(clk), .reset(reset),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .meas_data(meas_data), .multi_fpga(multi_fpga), .fusion_on(fusion_on),
      .decode_start(decode_start), .decode_done(decode_done), .decode_iters(decode_iters)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (reset === 1'b0 && decode_start === 1'b1) start_cnt++;
      if (reset === 1'b0 && tx_valid === 1'b1 && tx_ready === 1'b1) xfer_cnt++;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [63:0] mk_msg(input logic [7:0] typ, input logic [7:0] flags);
      logic [31:0] mid;
      mid = $urandom;
      return {8'h01, 8'h00, typ, mid, flags};
   endfunction

   function automatic logic [64*MW*2-1:0] exp_packed();
      logic [64*MW*2-1:0] v;
      for (int i = 0; i < 2*MW; i++) v[i*64 +: 64] = exp_meas[i];
      return v;
   endfunction

   function automatic logic [63:0] exp_result(input logic [7:0] iters, input int k);
      logic [15:0] cyc;
      logic        sat;
      sat = (k >= 65535);
      cyc = sat ? 16'hFFFF : 16'(k);
      return {8'h00, LID, iters, cyc, 23'b0, sat};
   endfunction

   task automatic do_reset();
      reset = 1'b1; rx_valid = 1'b0; tx_ready = 1'b0; decode_done = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      for (int i = 0; i < 2*MW; i++) exp_meas[i] = '0;
   endtask

   task automatic send_word(input logic [63:0] w);
      int n;
      n = 0;
      rx_data = w; rx_valid = 1'b1;
      while (rx_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
      checks++;
      if (rx_ready !== 1'b1) begin
         failures++;
         $display("FAIL rx_accept_timeout rx_ready=%b required=1", rx_ready);
      end
      @(posedge clk); #1;
      rx_valid = 1'b0;
   endtask

   task automatic send_stage(input bit stage, input bit expect_decode);
      logic [63:0] w;
      send_word(mk_msg(MEASUREMENT_DATA_HEADER, {7'b0, stage}));
      for (int i = 0; i < MW; i++) begin
         w = {$urandom, $urandom};
         send_word(w);
         exp_meas[int'(stage)*MW + i] = w;
      end
      checks++;
      if (decode_start !== expect_decode) begin
         failures++;
         $display("FAIL decode_start_after_stage%0d got=%b required=%b", stage, decode_start, expect_decode);
      end
   endtask

   // Entered in the first DECODE cycle; done is raised in the k-th DECODE cycle.
   task automatic run_decode(input int k, input logic [7:0] iters);
      checks++;
      if (rx_ready !== 1'b0 || tx_valid !== 1'b0) begin
         failures++;
         $display("FAIL decode_handshake rx_ready=%b tx_valid=%b required=0/0", rx_ready, tx_valid);
      end
      for (int i = 1; i < k; i++) begin @(posedge clk); #1; end
      decode_done = 1'b1; decode_iters = iters;
      @(posedge clk); #1;
      decode_done = 1'b0; decode_iters = 8'($urandom);
   endtask

   task automatic collect_result(input logic [63:0] exp, input int hold);
      int x0;
      x0 = xfer_cnt;
      tx_ready = 1'b0;
      for (int i = 0; i <= hold; i++) begin
         checks++;
         if (tx_valid !== 1'b1 || tx_data !== exp) begin
            failures++;
            $display("FAIL result_word cyc=%0d valid=%b data=%h required=%h", i, tx_valid, tx_data, exp);
         end
         if (i < hold) begin @(posedge clk); #1; end
      end
      tx_ready = 1'b1;
      @(posedge clk); #1;
      tx_ready = 1'b0;
      checks++;
      if (tx_valid !== 1'b0 || rx_ready !== 1'b1 || xfer_cnt !== x0 + 1) begin
         failures++;
         $display("FAIL result_transfer valid=%b rx_ready=%b xfers=%0d required=0/1/%0d",
                  tx_valid, rx_ready, xfer_cnt - x0, 1);
      end
   endtask

   task automatic run_job(input logic [1:0] flags, input bit stage_nf, input int k,
                          input logic [7:0] iters, input int hold);
      int s0;
      s0 = start_cnt;
      send_word(mk_msg(START_DECODING_MSG, {6'b0, flags}));
      checks++;
      if (multi_fpga !== flags[0] || fusion_on !== flags[1]) begin
         failures++;
         $display("FAIL start_flags multi=%b fusion=%b required=%b/%b", multi_fpga, fusion_on, flags[0], flags[1]);
      end
      if (flags[1]) begin
         send_stage(1'b0, 1'b0);
         send_stage(1'b1, 1'b1);
      end else begin
         send_stage(stage_nf, 1'b1);
      end
      checks++;
      if (meas_data !== exp_packed()) begin
         failures++;
         $display("FAIL meas_data got=%h required=%h", meas_data, exp_packed());
      end
      run_decode(k, iters);
      checks++;
      if (start_cnt !== s0 + 1) begin
         failures++;
         $display("FAIL decode_start_pulses got=%0d required=1", start_cnt - s0);
      end
      collect_result(exp_result(iters, k), hold);
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (tx_valid !== 1'b0 || tx_data !== 64'h0 || decode_start !== 1'b0 || multi_fpga !== 1'b0 ||
          fusion_on !== 1'b0 || meas_data !== '0 || rx_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_values tx_valid=%b tx_data=%h start=%b multi=%b fusion=%b rx_ready=%b required=0/0/0/0/0/1",
                  tx_valid, tx_data, decode_start, multi_fpga, fusion_on, rx_ready);
      end
   endtask

   task automatic test_junk_idle();
      int s0;
      s0 = start_cnt;
      send_word(mk_msg(MEASUREMENT_DATA_HEADER, 8'h00));
      send_word(mk_msg(8'h7E, 8'h03));
      send_word(mk_msg(8'h7E, 8'h01));
      send_word(mk_msg(MEASUREMENT_DATA_HEADER, 8'h01));
      decode_done = 1'b1; decode_iters = 8'h55;
      @(posedge clk); #1;
      decode_done = 1'b0;
      repeat (3) @(posedge clk); #1;
      checks++;
      if (meas_data !== exp_packed() || rx_ready !== 1'b1 || tx_valid !== 1'b0 || start_cnt !== s0 ||
          multi_fpga !== 1'b0 || fusion_on !== 1'b0) begin
         failures++;
         $display("FAIL junk_idle meas=%h rx_ready=%b tx_valid=%b starts=%0d required=%h/1/0/0",
                  meas_data, rx_ready, tx_valid, start_cnt - s0, exp_packed());
      end
   endtask

   task automatic test_non_fusion();
      int s0;
      logic [63:0] exp;
      s0 = start_cnt;
      exp = exp_result(8'd7, 10);
      send_word(mk_msg(START_DECODING_MSG, 8'h00));
      send_stage(1'b0, 1'b1);
      checks++;
      if (meas_data[127:0] !== {exp_meas[1], exp_meas[0]}) begin
         failures++;
         $display("FAIL nf_meas_low got=%h required=%h", meas_data[127:0], {exp_meas[1], exp_meas[0]});
      end
      run_decode(10, 8'd7);
      checks++;
      if (tx_data[47:40] !== 8'd7 || tx_data[39:24] !== 16'd10 || tx_data[55:48] !== 8'd1) begin
         failures++;
         $display("FAIL nf_fields iters=%0d cycles=%0d src=%0d required=7/10/1",
                  tx_data[47:40], tx_data[39:24], tx_data[55:48]);
      end
      checks++;
      if (start_cnt !== s0 + 1) begin
         failures++;
         $display("FAIL nf_start_pulses got=%0d required=1", start_cnt - s0);
      end
      collect_result(exp, 0);
   endtask

   task automatic test_fusion();
      run_job(2'b10, 1'b0, $urandom_range(2, 30), 8'($urandom), 1);
   endtask

   task automatic test_backpressure();
      run_job(2'b01, 1'b0, $urandom_range(3, 20), 8'($urandom), 5);
   endtask

   task automatic test_reset_mid_load();
      send_word(mk_msg(START_DECODING_MSG, 8'h02));
      send_word(mk_msg(MEASUREMENT_DATA_HEADER, 8'h00));
      send_word({$urandom, $urandom});
      do_reset();
      checks++;
      if (meas_data !== '0 || rx_ready !== 1'b1 || tx_valid !== 1'b0 || fusion_on !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_load meas=%h rx_ready=%b tx_valid=%b fusion=%b required=0/1/0/0",
                  meas_data, rx_ready, tx_valid, fusion_on);
      end
      run_job(2'b00, 1'b0, 4, 8'd3, 0);
   endtask

   task automatic test_random();
      for (int n = 0; n < 8; n++)
         run_job(2'($urandom_range(0, 3)), 1'($urandom), $urandom_range(1, 40),
                 8'($urandom), $urandom_range(0, 3));
   endtask

   task automatic test_saturation();
      run_job(2'b00, 1'b1, 70000, 8'($urandom), 0);
   endtask

   initial begin
      test_reset();
      test_junk_idle();
      test_non_fusion();
      test_fusion();
      test_backpressure();
      test_reset_mid_load();
      test_random();
      test_saturation();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
